// File: rtl/arch_defs_pkg.sv
// -----------------------------------------------------------------------------
// arch_defs_pkg
// Shared architecture definitions for the computer top level. This slice holds
// the run-controller state encoding, its default counter width and a helper
// that classifies the stopped states.
// -----------------------------------------------------------------------------
package arch_defs_pkg;

    // Debug/run sequencer state. The encoding is visible on the run_state port,
    // so the numeric values are fixed.
    typedef enum logic [2:0] {
        HALTED     = 3'd0,
        RUN        = 3'd1,
        STEP_CYC   = 3'd2,
        STEP_INSTR = 3'd3,
        BREAK      = 3'd4
    } run_state_t;

    // Default width of the executed-cycle counter.
    localparam int RUN_CTRL_CNT_WIDTH = 32;

    // The CPU is parked (clock enable held low) in these states.
    function automatic logic is_stop_state(input run_state_t s);
        return (s == HALTED) || (s == BREAK);
    endfunction

endpackage : arch_defs_pkg

// File: rtl/run_cycle_counter.sv
// -----------------------------------------------------------------------------
// run_cycle_counter
// Free-running up counter with enable and synchronous clear. It wraps modulo
// 2^WIDTH. Clear has priority over enable.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset (count returns to 0)
//   i_en     in   count this cycle
//   i_clr    in   clear to 0 this cycle (wins over i_en)
//   o_count  out  current count
// -----------------------------------------------------------------------------
module run_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous, so it lives inside the clocked
    // branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule : run_cycle_counter

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
// Debug/run sequencer that gates the CPU clock enable. Supports free-run, halt,
// single-cycle step, single-instruction step and one PC breakpoint. Counts the
// enabled CPU cycles for benches and the front panel.
//
// Optional build macro RUN_CTRL_WATCHDOG_EN adds a run-length watchdog. It adds
// the wd_limit/wd_trip_o ports. When the macro is undefined, RUN is unbounded.
//
// Ports:
//   clk               in   system clock
//   reset             in   synchronous, active-high reset
//   run_req           in   pulse: start free-running
//   halt_req          in   pulse: stop (highest priority)
//   step_cyc_req      in   pulse: advance CPU one clock
//   step_instr_req    in   pulse: advance CPU to next instruction boundary
//   clr_count         in   pulse: clear cycle counter
//   bp_en             in   breakpoint enable (level)
//   bp_addr           in   breakpoint PC
//   pc_i              in   CPU program counter
//   instr_boundary_i  in   CPU is at microstep 0
//   cpu_halt_i        in   CPU decoded HLT
//   wd_limit          in   watchdog limit, 0 = off       (watchdog build only)
//   cpu_clk_en        out  CPU clock enable
//   run_state         out  encoded state
//   halted_o          out  state is HALTED or BREAK
//   bp_hit_o          out  sticky: last stop was a breakpoint
//   wd_trip_o         out  sticky: last RUN hit the limit (watchdog build only)
//   cycle_count       out  enabled cycles since reset/clear
// -----------------------------------------------------------------------------
module cpu_run_controller
    import arch_defs_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = RUN_CTRL_CNT_WIDTH,
    parameter int AUTO_RUN   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_cyc_req,
    input  logic                  step_instr_req,
    input  logic                  clr_count,
    input  logic                  bp_en,
    input  logic [ADDR_WIDTH-1:0] bp_addr,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  instr_boundary_i,
    input  logic                  cpu_halt_i,
`ifdef RUN_CTRL_WATCHDOG_EN
    input  logic [CNT_WIDTH-1:0]  wd_limit,
    output logic                  wd_trip_o,
`endif
    output logic                  cpu_clk_en,
    output run_state_t            run_state,
    output logic                  halted_o,
    output logic                  bp_hit_o,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam run_state_t RESET_STATE = (AUTO_RUN != 0) ? RUN : HALTED;

    run_state_t r_state;
    run_state_t w_next_state;
    logic       r_first;       // no enabled cycle yet since leaving a stop
    logic       w_next_first;
    logic       r_bp_hit;
    logic       w_next_bp_hit;
    logic       w_leave_stop;  // this cycle exits HALTED/BREAK
    logic       w_active;
    logic       w_bp_match;
    logic       w_stop_now;
    logic       w_step_done;
    logic       w_wd_trip;
    logic       w_clk_en;

    // The breakpoint is masked until the CPU has advanced once. This lets a
    // resume from BREAK leave the breakpoint address without re-triggering.
    assign w_bp_match  = bp_en && instr_boundary_i && (pc_i == bp_addr) && !r_first;
    assign w_stop_now  = cpu_halt_i || w_bp_match;
    assign w_active    = (r_state == RUN) || (r_state == STEP_CYC) || (r_state == STEP_INSTR);
    // An instruction step ends at the next boundary after it has moved.
    // The boundary cycle itself is not enabled.
    assign w_step_done = (r_state == STEP_INSTR) && instr_boundary_i && !r_first;
    assign w_clk_en    = w_active && !w_stop_now && !halt_req && !w_step_done && !w_wd_trip;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RESET_STATE;
            r_first  <= 1'b1;
            r_bp_hit <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_first  <= w_next_first;
            r_bp_hit <= w_next_bp_hit;
        end
    end

    // NOTE: every output of this block is given a default before any branch.
    // This keeps paths that don't assign a signal from inferring a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_first  = r_first;
        w_next_bp_hit = r_bp_hit;
        w_leave_stop  = 1'b0;

        if (w_clk_en) begin
            w_next_first = 1'b0;
        end

        if (halt_req) begin
            w_next_state = HALTED;
        end else begin
            case (r_state)
                HALTED, BREAK: begin
                    if (step_instr_req) begin
                        w_next_state = STEP_INSTR;
                        w_leave_stop = 1'b1;
                    end else if (step_cyc_req) begin
                        w_next_state = STEP_CYC;
                        w_leave_stop = 1'b1;
                    end else if (run_req) begin
                        w_next_state = RUN;
                        w_leave_stop = 1'b1;
                    end
                end
                RUN: begin
                    if (cpu_halt_i) begin
                        w_next_state = HALTED;
                    end else if (w_bp_match) begin
                        w_next_state  = BREAK;
                        w_next_bp_hit = 1'b1;
                    end else if (w_wd_trip) begin
                        w_next_state = HALTED;
                    end
                end
                STEP_CYC: begin
                    // One cycle only: either it was enabled or a stop condition
                    // blocked it. Either way the step is over.
                    if (w_bp_match && !cpu_halt_i) begin
                        w_next_state  = BREAK;
                        w_next_bp_hit = 1'b1;
                    end else begin
                        w_next_state = HALTED;
                    end
                end
                STEP_INSTR: begin
                    if (cpu_halt_i) begin
                        w_next_state = HALTED;
                    end else if (w_bp_match) begin
                        w_next_state  = BREAK;
                        w_next_bp_hit = 1'b1;
                    end else if (w_step_done) begin
                        w_next_state = HALTED;
                    end
                end
                default: w_next_state = HALTED;
            endcase
        end

        if (w_leave_stop) begin
            w_next_bp_hit = 1'b0;
            w_next_first  = 1'b1;
        end
    end

    // ------------------------------------------------------ cycle counter
    run_cycle_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cycle_counter (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_clk_en),
        .i_clr   (clr_count),
        .o_count (cycle_count)
    );

`ifdef RUN_CTRL_WATCHDOG_EN
    // ------------------------------------------------------------ watchdog
    logic [CNT_WIDTH-1:0] w_run_count;
    logic                 w_run_enter;
    logic                 w_wd_fire;
    logic                 r_wd_trip;

    // The run counter restarts on every entry to RUN. It only counts enabled
    // cycles spent in RUN.
    assign w_run_enter = (r_state != RUN) && (w_next_state == RUN);

    run_cycle_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_wd_counter (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_clk_en && (r_state == RUN)),
        .i_clr   (w_run_enter),
        .o_count (w_run_count)
    );

    assign w_wd_trip = (r_state == RUN) && (wd_limit != '0) && (w_run_count >= wd_limit);
    // The trip only counts when the FSM actually takes the watchdog exit. A
    // halt request, HLT or breakpoint in the same cycle has priority.
    assign w_wd_fire = w_wd_trip && !halt_req && !w_stop_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_trip <= 1'b0;
        end else if (w_leave_stop) begin
            r_wd_trip <= 1'b0;
        end else if (w_wd_fire) begin
            r_wd_trip <= 1'b1;
        end
    end

    assign wd_trip_o = r_wd_trip;
`else
    assign w_wd_trip = 1'b0;
`endif

    // -------------------------------------------------------------- outputs
    assign cpu_clk_en = w_clk_en;
    assign run_state  = r_state;
    assign halted_o   = is_stop_state(r_state);
    assign bp_hit_o   = r_bp_hit;

endmodule : cpu_run_controller

// File: tb/tb_cpu_run_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_controller
// Bench for cpu_run_controller. A tiny behavioural CPU supplies pc_i,
// instr_boundary_i and cpu_halt_i.
//
// Each instruction starts with a fetch cycle (microstep 0) followed by a decode
// cycle. One-byte ops (NOP, HLT) finish in decode; HLT raises the halt flag.
// Two-byte ops (LDI_A, LDI_C, JMP) add an operand fetch and an execute cycle:
// 3 enabled cycles total.
//
// Expected snapshots are queued before each command. A monitor pops one
// snapshot every time halted_o rises and compares it with the DUT and the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_run_controller;
    import arch_defs_pkg::*;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LDI_A = 8'h01;
    localparam logic [7:0] OP_LDI_C = 8'h02;
    localparam logic [7:0] OP_JMP   = 8'h03;
    localparam logic [7:0] OP_HLT   = 8'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_req = 1'b0, halt_req = 1'b0, step_cyc_req = 1'b0;
    logic        step_instr_req = 1'b0, clr_count = 1'b0, bp_en = 1'b0;
    logic [15:0] bp_addr = 16'h0000;
    logic [15:0] pc_i;
    logic        instr_boundary_i, cpu_halt_i;
    logic        cpu_clk_en, halted_o, bp_hit_o;
    run_state_t  run_state;
    logic [31:0] cycle_count;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic [31:0] wd_limit = 32'd0;
    logic        wd_trip_o;
`endif

    always #5 clk = ~clk;

    cpu_run_controller dut (
        .clk              (clk),
        .reset            (reset),
        .run_req          (run_req),
        .halt_req         (halt_req),
        .step_cyc_req     (step_cyc_req),
        .step_instr_req   (step_instr_req),
        .clr_count        (clr_count),
        .bp_en            (bp_en),
        .bp_addr          (bp_addr),
        .pc_i             (pc_i),
        .instr_boundary_i (instr_boundary_i),
        .cpu_halt_i       (cpu_halt_i),
`ifdef RUN_CTRL_WATCHDOG_EN
        .wd_limit         (wd_limit),
        .wd_trip_o        (wd_trip_o),
`endif
        .cpu_clk_en       (cpu_clk_en),
        .run_state        (run_state),
        .halted_o         (halted_o),
        .bp_hit_o         (bp_hit_o),
        .cycle_count      (cycle_count)
    );

    // ------------------------------------------------------------ CPU model
    logic [7:0]  mem [0:255];
    logic [15:0] m_pc;
    logic [1:0]  m_ustep;
    logic [7:0]  m_ir, m_opnd, m_a, m_c;
    logic        m_hlt;
    int          tb_en;   // enabled cycles seen by the model

    assign pc_i             = m_pc;
    assign instr_boundary_i = (m_ustep == 2'd0);
    assign cpu_halt_i       = m_hlt;

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= '0; m_ustep <= '0; m_ir <= '0; m_opnd <= '0;
            m_a <= '0; m_c <= '0; m_hlt <= 1'b0; tb_en <= 0;
        end else if (cpu_clk_en) begin
            tb_en <= tb_en + 1;
            case (m_ustep)
                2'd0: begin
                    m_ir <= mem[m_pc[7:0]]; m_pc <= m_pc + 16'd1; m_ustep <= 2'd1;
                end
                2'd1: begin
                    if (m_ir == OP_NOP) begin
                        m_ustep <= 2'd0;
                    end else if (m_ir == OP_HLT) begin
                        m_hlt <= 1'b1; m_ustep <= 2'd0;
                    end else begin
                        m_opnd <= mem[m_pc[7:0]]; m_pc <= m_pc + 16'd1; m_ustep <= 2'd2;
                    end
                end
                default: begin
                    if (m_ir == OP_LDI_A) m_a <= m_opnd;
                    else if (m_ir == OP_LDI_C) m_c <= m_opnd;
                    else if (m_ir == OP_JMP) m_pc <= {8'h00, m_opnd};
                    m_ustep <= 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        int          id;
        run_state_t  st;
        logic        bp;
        logic [31:0] cnt;
        logic [15:0] pc;
        logic [7:0]  a;
        logic [7:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    bit   prev_halted = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_stop(input int id, input run_state_t st, input logic bp,
                               input logic [31:0] cnt, input logic [15:0] pc,
                               input logic [7:0] a, input logic [7:0] c);
        exp_t e;
        e.id = id; e.st = st; e.bp = bp; e.cnt = cnt; e.pc = pc; e.a = a; e.c = c;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && halted_o && !prev_halted) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_stop: state=%0d count=%0d, expected no stop",
                             run_state, cycle_count);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("ev%0d_state", e.id), 64'(run_state), 64'(e.st));
                    check($sformatf("ev%0d_bp_hit", e.id), 64'(bp_hit_o), 64'(e.bp));
                    check($sformatf("ev%0d_cycle_count", e.id), 64'(cycle_count), 64'(e.cnt));
                    check($sformatf("ev%0d_enabled_cycles", e.id), 64'(tb_en), 64'(e.cnt));
                    check($sformatf("ev%0d_pc", e.id), 64'(pc_i), 64'(e.pc));
                    check($sformatf("ev%0d_reg_a", e.id), 64'(m_a), 64'(e.a));
                    check($sformatf("ev%0d_reg_c", e.id), 64'(m_c), 64'(e.c));
                end
            end
            prev_halted = halted_o;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Holds the selected request high across exactly one rising edge.
    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            0: run_req = 1'b1;
            1: halt_req = 1'b1;
            2: step_cyc_req = 1'b1;
            3: step_instr_req = 1'b1;
            default: clr_count = 1'b1;
        endcase
        @(posedge clk); #1;
        run_req = 1'b0; halt_req = 1'b0; step_cyc_req = 1'b0;
        step_instr_req = 1'b0; clr_count = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n = 0;
        while (halted_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (halted_o !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: halted_o=%0b after %0d cycles, expected 1", name, halted_o, n);
        end
        @(negedge clk);
    endtask

    task automatic load_prog(input int sel);
        for (int i = 0; i < 256; i++) mem[i] = OP_NOP;
        if (sel == 0) begin
            mem[0] = OP_LDI_A; mem[1] = 8'hE1; mem[2] = OP_HLT;
        end else if (sel == 1) begin
            mem[0] = OP_LDI_A; mem[1] = 8'hE1; mem[2] = OP_LDI_C; mem[3] = 8'hFE;
            mem[4] = OP_NOP;   mem[5] = OP_NOP; mem[6] = OP_HLT;
        end else begin
            mem[0] = OP_JMP;   mem[1] = 8'h00;
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin : stimulus
        // Test A: reset, then a free run to HLT (LDI_A 3 cycles + HLT 2 cycles).
        load_prog(0);
        do_reset();
        check("reset_state", 64'(run_state), 64'(HALTED));
        check("reset_halted", 64'(halted_o), 64'd1);
        check("reset_bp_hit", 64'(bp_hit_o), 64'd0);
        check("reset_count", 64'(cycle_count), 64'd0);
        check("reset_clk_en", 64'(cpu_clk_en), 64'd0);
        expect_stop(1, HALTED, 1'b0, 32'd5, 16'd3, 8'hE1, 8'h00);
        pulse(0);
        check("run_clk_en_next", 64'(cpu_clk_en), 64'd1);
        wait_halted("run_to_hlt", 50);

        // Test B: three single-cycle steps through LDI_A.
        load_prog(1);
        do_reset();
        expect_stop(2, HALTED, 1'b0, 32'd1, 16'd1, 8'h00, 8'h00);
        expect_stop(3, HALTED, 1'b0, 32'd2, 16'd2, 8'h00, 8'h00);
        expect_stop(4, HALTED, 1'b0, 32'd3, 16'd2, 8'hE1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            pulse(2);
            check($sformatf("step%0d_clk_en_on", k), 64'(cpu_clk_en), 64'd1);
            @(posedge clk); #1;
            check($sformatf("step%0d_clk_en_off", k), 64'(cpu_clk_en), 64'd0);
            wait_halted("step_cyc", 10);
        end

        // Test C: instruction step over LDI_C FE (3 enabled cycles, PC 2 -> 4).
        expect_stop(5, HALTED, 1'b0, 32'd6, 16'd4, 8'hE1, 8'hFE);
        pulse(3);
        check("step_instr_clk_en", 64'(cpu_clk_en), 64'd1);
        wait_halted("step_instr", 20);

        // Test D: breakpoint at 0x0004, then resume past it to HLT at 6.
        do_reset();
        bp_en = 1'b1;
        bp_addr = 16'h0004;
        expect_stop(6, BREAK, 1'b1, 32'd6, 16'd4, 8'hE1, 8'hFE);
        pulse(0);
        wait_halted("run_to_bp", 50);
        check("break_clk_en", 64'(cpu_clk_en), 64'd0);
        expect_stop(7, HALTED, 1'b0, 32'd12, 16'd7, 8'hE1, 8'hFE);
        pulse(0);
        check("resume_clk_en", 64'(cpu_clk_en), 64'd1);
        wait_halted("resume", 50);
        pulse(4);
        check("clr_count", 64'(cycle_count), 64'd0);

        // Test E: halt_req beats run_req, then a reset in the middle of a step.
        bp_en = 1'b0;
        do_reset();
        @(posedge clk); #1;
        halt_req = 1'b1;
        run_req = 1'b1;
        @(posedge clk); #1;
        halt_req = 1'b0;
        run_req = 1'b0;
        check("halt_wins_state", 64'(run_state), 64'(HALTED));
        check("halt_wins_clk_en", 64'(cpu_clk_en), 64'd0);
        repeat (3) @(negedge clk);
        check("halt_wins_count", 64'(cycle_count), 64'd0);

        pulse(3);
        check("mid_step_state", 64'(run_state), 64'(STEP_INSTR));
        @(posedge clk); #1;
        check("mid_step_count", 64'(cycle_count), 64'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_step_state", 64'(run_state), 64'(HALTED));
        check("reset_mid_step_count", 64'(cycle_count), 64'd0);
        check("reset_mid_step_bp_hit", 64'(bp_hit_o), 64'd0);
        check("reset_mid_step_clk_en", 64'(cpu_clk_en), 64'd0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;

`ifdef RUN_CTRL_WATCHDOG_EN
        // Test F: JMP-to-self loop stopped by a 10-cycle watchdog
        // (3 loops of 3 cycles plus one fetch, leaving PC at 1).
        load_prog(2);
        do_reset();
        wd_limit = 32'd10;
        expect_stop(8, HALTED, 1'b0, 32'd10, 16'd1, 8'h00, 8'h00);
        pulse(0);
        wait_halted("watchdog", 50);
        check("wd_trip", 64'(wd_trip_o), 64'd1);
        wd_limit = 32'd0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : global_timeout
        #100000;
        $display("FAIL global_timeout: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule : tb_cpu_run_controller
